// File: rtl/rv32i_ifetch.sv
// rv32i instruction fetch: sequential address generation, credit-limited imem requests,
// prefetch FIFO to decode, redirect flush. Optional misaligned-redirect trap: RV32I_IFETCH_MISALIGN_TRAP_EN.
module rv32i_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   sum_t;

    localparam ptr_t PTR_ONE    = ptr_t'(1);
    localparam cnt_t CNT_ONE    = cnt_t'(1);
    localparam sum_t CREDIT_MAX = sum_t'(FIFO_DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        drop_cnt_q, drop_cnt_d;

    logic [31:0] tag_mem_q [FIFO_DEPTH];
    logic [31:0] tag_mem_d [FIFO_DEPTH];
    ptr_t        tag_wr_q, tag_wr_d;
    ptr_t        tag_rd_q, tag_rd_d;

    logic [31:0] fifo_pc_q    [FIFO_DEPTH];
    logic [31:0] fifo_pc_d    [FIFO_DEPTH];
    logic [31:0] fifo_instr_q [FIFO_DEPTH];
    logic [31:0] fifo_instr_d [FIFO_DEPTH];
    ptr_t        fifo_wr_q, fifo_wr_d;
    ptr_t        fifo_rd_q, fifo_rd_d;
    cnt_t        count_q, count_d;

    logic [31:0] redirect_target;
    sum_t        credit_sum;
    logic        fetch_en;
    logic        trap_wr;
    logic        req_fire;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        fifo_we;
    logic        pop;

`ifdef RV32I_IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_RUN,
        ST_TRAP,
        ST_HALT
    } state_t;

    state_t state_q, state_d;
    logic   fifo_fault_q [FIFO_DEPTH];
    logic   fifo_fault_d [FIFO_DEPTH];

    // A misaligned redirect parks here; fetch_pc_q holds the faulting pc for the trap entry.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (redirect_pc[1:0] != 2'b00) ? ST_TRAP : ST_RUN;
        end else if (state_q == ST_TRAP) begin
            state_d = ST_HALT;
        end
        trap_wr         = (state_q == ST_TRAP) && !redirect_valid;
        fetch_en        = (state_q == ST_RUN);
        redirect_target = redirect_pc;
    end
`else
    always_comb begin
        trap_wr         = 1'b0;
        fetch_en        = 1'b1;
        redirect_target = redirect_pc & ~32'd3;
    end
`endif

    always_comb begin
        credit_sum     = sum_t'(outstanding_q) + sum_t'(count_q);
        imem_req_valid = !rst && !redirect_valid && fetch_en && (credit_sum < CREDIT_MAX);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
        rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
        fifo_we        = rsp_keep || trap_wr;
        pop            = (count_q != '0) && if_ready;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        tag_mem_d     = tag_mem_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        count_d       = count_q;
`ifdef RV32I_IFETCH_MISALIGN_TRAP_EN
        fifo_fault_d  = fifo_fault_q;
`endif

        if (req_fire) begin
            tag_mem_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d            = tag_wr_q + PTR_ONE;
            fetch_pc_d          = fetch_pc_q + 32'd4;
        end

        case ({req_fire, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
        end
        if (rsp_keep) begin
            tag_rd_d = tag_rd_q + PTR_ONE;
        end

        if (fifo_we) begin
            fifo_pc_d[fifo_wr_q]    = trap_wr ? fetch_pc_q : tag_mem_q[tag_rd_q];
            fifo_instr_d[fifo_wr_q] = trap_wr ? NOP_INSTR : imem_rsp_data;
`ifdef RV32I_IFETCH_MISALIGN_TRAP_EN
            fifo_fault_d[fifo_wr_q] = trap_wr;
`endif
            fifo_wr_d = fifo_wr_q + PTR_ONE;
        end
        if (pop) begin
            fifo_rd_d = fifo_rd_q + PTR_ONE;
        end

        case ({fifo_we, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flush after the pop: every still-unreturned response, minus the one arriving now, is stale.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            drop_cnt_d = imem_rsp_valid ? (outstanding_q - CNT_ONE) : outstanding_q;
            tag_rd_d   = tag_wr_q;
            fifo_rd_d  = fifo_wr_q;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            tag_mem_q     <= '{default: '0};
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_pc_q     <= '{default: '0};
            fifo_instr_q  <= '{default: '0};
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            count_q       <= '0;
`ifdef RV32I_IFETCH_MISALIGN_TRAP_EN
            fifo_fault_q  <= '{default: 1'b0};
            state_q       <= ST_RUN;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            tag_mem_q     <= tag_mem_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            count_q       <= count_d;
`ifdef RV32I_IFETCH_MISALIGN_TRAP_EN
            fifo_fault_q  <= fifo_fault_d;
            state_q       <= state_d;
`endif
        end
    end

    always_comb begin
        if_valid = (count_q != '0);
        if_pc    = fifo_pc_q[fifo_rd_q];
        if_instr = fifo_instr_q[fifo_rd_q];
`ifdef RV32I_IFETCH_MISALIGN_TRAP_EN
        if_fault = if_valid && fifo_fault_q[fifo_rd_q];
`else
        if_fault = 1'b0;
`endif
    end

endmodule

// File: doc/rv32i_ifetch.md
# rv32i_ifetch

Instruction fetch front end for the rv32i core. It sits directly upstream of decode. It generates sequential fetch addresses starting at `RESET_PC` and issues them to instruction memory over a valid/ready request channel. Returned instruction words go into a small prefetch FIFO, and the FIFO presents {pc, instr} to decode with a valid/ready handshake. Branch/jump redirects flush the FIFO and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 4, prefetch entries; power of two, 2..16; also the maximum outstanding requests plus buffered entries
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `redirect_valid` input 1: branch unit requests a PC change this cycle
- `redirect_pc` input 32: new fetch address
- `imem_req_valid` output 1: fetch request offered
- `imem_req_ready` input 1: memory accepts request
- `imem_req_addr` output 32: word address of request
- `imem_rsp_valid` input 1: instruction word returned; in order, one per accepted request, latency ≥1 cycle, no backpressure
- `imem_rsp_data` input 32: instruction word
- `if_valid` output 1: FIFO head valid to decode
- `if_ready` input 1: decode consumes head
- `if_pc` output 32: PC of head entry
- `if_instr` output 32: instruction of head entry
- `if_fault` output 1: head entry is a misaligned-fetch fault (only with macro; else constant 0)

## Operation
- Registers:
  - `fetch_pc` (next address to request)
  - `outstanding` (accepted, unreturned requests, 0..FIFO_DEPTH)
  - `drop_cnt` (responses still to discard)
  - FIFO of {pc, instr, fault} with rd/wr pointers and count
- Request fires when `imem_req_valid && imem_req_ready`. On fire: `fetch_pc += 4` (wraps modulo 2^32), `outstanding++`, and the request's PC is pushed into a pc-tag queue so the response can be paired with its PC.
- `imem_req_valid = !redirect_valid && (outstanding + count < FIFO_DEPTH)`. This credit rule guarantees every response has a FIFO slot; overflow is impossible. `imem_req_addr = fetch_pc`. Once asserted, valid and addr stay stable until fire, unless a redirect occurs.
- Response: `outstanding--`. If `drop_cnt != 0`, decrement `drop_cnt` and discard the word. Otherwise write {tagged pc, data, 0} to the FIFO.
- Decode pop happens when `if_valid && if_ready`. Outputs always show the FIFO head. When the FIFO is empty, `if_pc`/`if_instr` hold their last values and are don't-care.
- Redirect (`redirect_valid` = 1) takes effect at the clock edge:
  - FIFO and tag queue are flushed: count = 0.
  - `drop_cnt` = `outstanding` minus any response arriving in this same cycle. That response is itself discarded.
  - `fetch_pc` = `redirect_pc`.
  - No request is issued in the redirect cycle.
- Simultaneous events:
  - Redirect and pop in the same cycle: the pop completes (decode took the entry), then the flush is applied.
  - Response and pop in the same cycle with the FIFO full: legal, because credit guarantees space.
  - Back-to-back redirects: the last one wins, and `drop_cnt` accumulates correctly.

## Timing
- Reset values: `imem_req_valid`=0 during reset, `imem_req_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=0, `if_fault`=0. All counters are 0 and the FIFO is empty.
- First cycle after `rst` deasserts: `imem_req_valid`=1 with addr=`RESET_PC`.
- Sustained throughput: one request per cycle when memory is always ready and decode is always ready.
- Response to decode: the response is registered into the FIFO at edge N, so `if_valid`=1 in cycle N+1. There is no combinational bypass.
- Redirect in cycle R: `if_valid`=0 in cycle R+1. The first request to `redirect_pc` is offered in cycle R+1.
- Reset mid-operation clears all state asynchronously. Any in-flight memory responses after reset are the memory's responsibility; imem must also be reset.

## Configuration
- `RV32I_IFETCH_MISALIGN_TRAP_EN` defined: a redirect with `redirect_pc[1:0] != 0` issues no memory request. Instead, at the next edge, the block writes one FIFO entry {pc=redirect_pc, instr=32'h0000_0013, fault=1}, then stalls with `imem_req_valid`=0 until the next redirect.
- Undefined: `redirect_pc[1:0]` is forced to 2'b00 and `if_fault` is tied 0.

## Test plan
- Reset, always-ready memory with 1-cycle latency, decode always ready -> requests at 0x0, 0x4, 0x8… on consecutive cycles; `if_pc` sequence 0x0, 0x4, 0x8 starting 2 cycles after the first request.
- `if_ready`=0 for 10 cycles -> exactly 4 entries buffered (`FIFO_DEPTH`=4), no further fire, no lost words. Releasing ready yields in-order PCs.
- Memory latency 3 with 3 outstanding requests, then redirect to 0x100 -> the 3 stale responses are dropped, the next `if_pc` is 0x100, and no stale word reaches decode.
- Redirect in the same cycle as a pop and a response -> the popped entry is counted once, the response is dropped, and `if_valid`=0 the next cycle.
- `imem_req_ready` toggling randomly -> `imem_req_addr` stays stable while valid is unaccepted, and the `if_pc` stream has no gaps or duplicates.
- With the macro defined, redirect to 0x102 -> one entry with `if_fault`=1, pc 0x102, no imem request; a later redirect to 0x200 resumes fetching.
